// File: rtl/oled_refresh_sequencer_pkg.sv
// Shared types and constants for the SSD1306 refresh sequencer and its byte sender.
// Holds the FSM encodings, the panel init command table and the page-address command bytes.
package oled_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_INIT,
        ST_PAGE_CMD,
        ST_FETCH,
        ST_PAGE_DATA,
        ST_FRAME_END
    } seq_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT,
        TX_ISSUE,
        TX_DRAIN
    } tx_state_t;

    localparam int INIT_LEN = 25;

    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
        8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
        8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

    localparam logic [7:0] PAGE_BASE = 8'hB0;
    localparam logic [7:0] COL_LO    = 8'h00;
    localparam logic [7:0] COL_HI    = 8'h10;

endpackage

// File: rtl/oled_refresh_sequencer_if.sv
// Frame-buffer read port and spi_master byte port seen by the refresh sequencer.
// master = sequencer side, slave = frame-buffer RAM / spi_master side.
interface oled_refresh_sequencer_if;

    logic       spi_wr_cmd;
    logic       recv_dc;
    logic [7:0] mosi_data;
    logic       spi_busy;
    logic       fb_rd;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;

    modport master (
        output spi_wr_cmd, recv_dc, mosi_data, fb_rd, fb_addr,
        input  spi_busy, fb_data
    );

    modport slave (
        input  spi_wr_cmd, recv_dc, mosi_data, fb_rd, fb_addr,
        output spi_busy, fb_data
    );

endinterface

// File: rtl/oled_refresh_sequencer_spi_byte_sender.sv
// Hands one byte to spi_master: raise wr until busy is seen, then wait for busy to clear.
// Latency: wr rises the cycle after accept (later if spi_master is still busy); ready only when idle, timeout if no ack.
module spi_byte_sender
    import oled_seq_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       tx_vld,
    output logic       tx_rdy,
    input  logic [7:0] tx_byte,
    input  logic       tx_dc,
    output logic       tx_done,
    output logic       tx_timeout,
    output logic       spi_wr_cmd,
    output logic       recv_dc,
    output logic [7:0] mosi_data,
    input  logic       spi_busy
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    tx_state_t     state;
    tx_state_t     nxt;
    logic [TW-1:0] tcnt;
    logic          ack_expired;

    assign ack_expired = (tcnt == TW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= TX_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            TX_IDLE:  if (tx_vld) nxt = spi_busy ? TX_WAIT : TX_ISSUE;
            TX_WAIT:  if (!spi_busy) nxt = TX_ISSUE;
            TX_ISSUE: begin
                if (spi_busy)         nxt = TX_DRAIN;
                else if (ack_expired) nxt = TX_IDLE;
            end
            TX_DRAIN: if (!spi_busy) nxt = TX_IDLE;
            default:  nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_rdy     = (state == TX_IDLE);
        spi_wr_cmd = (state == TX_ISSUE);
        tx_done    = (state == TX_DRAIN) && !spi_busy;
        tx_timeout = (state == TX_ISSUE) && !spi_busy && ack_expired;
    end

    // Byte and dc are captured once at accept so they stay put through ISSUE and DRAIN.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mosi_data <= 8'h00;
            recv_dc   <= 1'b0;
            tcnt      <= '0;
        end else begin
            if (tx_vld && tx_rdy) begin
                mosi_data <= tx_byte;
                recv_dc   <= tx_dc;
            end
            if (state == TX_ISSUE) tcnt <= tcnt + TW'(1);
            else                   tcnt <= '0;
        end
    end

endmodule

// File: rtl/oled_refresh_sequencer.sv
// SSD1306 sequencer: panel reset pulse, init table, then page-by-page frame refresh from the frame buffer.
// Latency: one byte in flight at a time, paced entirely by spi_busy; start is ignored while busy.
module oled_refresh_sequencer
    import oled_seq_pkg::*;
#(
    parameter int RST_LOW_CYCLES  = 1000,
    parameter int RST_WAIT_CYCLES = 1000,
    parameter int ACK_TIMEOUT     = 255,
    parameter int PAGES           = 8,
    parameter int COLS            = 128
) (
    input  logic clk,
    input  logic nrst,
    input  logic start,
    input  logic refresh_en,
    output logic busy,
    output logic init_done,
    output logic frame_done,
    output logic err,
    output logic oled_rst_n,
    oled_refresh_sequencer_if.master bus
);

    localparam int DLY_MAX = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES : RST_WAIT_CYCLES;
    localparam int DW      = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;

    seq_state_t    state;
    seq_state_t    nxt;
    logic [DW-1:0] dly_cnt;
    logic [2:0]    page;
    logic [6:0]    col;
    logic [4:0]    idx;
    logic          tx_pend;
    logic          tx_vld;
    logic          tx_rdy;
    logic          tx_dc;
    logic          tx_done;
    logic          tx_timeout;
    logic [7:0]    tx_byte;
    logic          fb_rd;
    logic          low_end;
    logic          wait_end;
    logic          init_last;
    logic          cmd_last;
    logic          col_last;
    logic          page_last;

    assign low_end   = (int'(dly_cnt) == RST_LOW_CYCLES - 1);
    // The INIT accept cycle counts as the last wait cycle, so wr rises exactly RST_WAIT_CYCLES after release.
    assign wait_end  = (int'(dly_cnt) >= RST_WAIT_CYCLES - 2);
    assign init_last = (int'(idx) == INIT_LEN - 1);
    assign cmd_last  = (idx == 5'd2);
    assign col_last  = (int'(col) == COLS - 1);
    assign page_last = (int'(page) == PAGES - 1);

    assign bus.fb_rd   = fb_rd;
    assign bus.fb_addr = {page, col};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (tx_timeout) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      if (start) nxt = init_done ? ST_PAGE_CMD : ST_RST_LOW;
                ST_RST_LOW:   if (low_end) nxt = ST_RST_WAIT;
                ST_RST_WAIT:  if (wait_end) nxt = ST_INIT;
                ST_INIT:      if (tx_done && init_last) nxt = ST_PAGE_CMD;
                ST_PAGE_CMD:  if (tx_done && cmd_last) nxt = ST_FETCH;
                ST_FETCH:     nxt = ST_PAGE_DATA;
                ST_PAGE_DATA: begin
                    if (tx_done) begin
                        if (!col_last)      nxt = ST_FETCH;
                        else if (page_last) nxt = ST_FRAME_END;
                        else                nxt = ST_PAGE_CMD;
                    end
                end
                ST_FRAME_END: nxt = refresh_en ? ST_PAGE_CMD : ST_IDLE;
                default:      nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        oled_rst_n = (state != ST_RST_LOW);
        fb_rd      = (state == ST_FETCH);
        frame_done = (state == ST_FRAME_END);
        tx_vld     = 1'b0;
        tx_byte    = 8'h00;
        tx_dc      = 1'b0;
        case (state)
            ST_INIT: begin
                tx_vld  = !tx_pend;
                tx_byte = INIT_ROM[idx];
            end
            ST_PAGE_CMD: begin
                tx_vld = !tx_pend;
                case (idx)
                    5'd0:    tx_byte = PAGE_BASE | {5'b00000, page};
                    5'd1:    tx_byte = COL_LO;
                    default: tx_byte = COL_HI;
                endcase
            end
            // fb_data is valid in the first PAGE_DATA cycle, which is exactly when the idle sender accepts it.
            ST_PAGE_DATA: begin
                tx_vld  = !tx_pend;
                tx_byte = bus.fb_data;
                tx_dc   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dly_cnt   <= '0;
            page      <= 3'd0;
            col       <= 7'd0;
            idx       <= 5'd0;
            tx_pend   <= 1'b0;
            init_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (tx_vld && tx_rdy)          tx_pend <= 1'b1;
            else if (tx_done || tx_timeout) tx_pend <= 1'b0;

            if (tx_timeout) err <= 1'b1;

            if ((state == ST_RST_LOW || state == ST_RST_WAIT) && nxt == state)
                dly_cnt <= dly_cnt + DW'(1);
            else
                dly_cnt <= '0;

            case (state)
                ST_IDLE, ST_FRAME_END: begin
                    page <= 3'd0;
                    col  <= 7'd0;
                    idx  <= 5'd0;
                end
                ST_INIT: begin
                    if (tx_done) begin
                        if (init_last) begin
                            init_done <= 1'b1;
                            idx       <= 5'd0;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                ST_PAGE_CMD: if (tx_done) idx <= cmd_last ? 5'd0 : idx + 5'd1;
                ST_PAGE_DATA: begin
                    if (tx_done) begin
                        if (col_last) begin
                            col  <= 7'd0;
                            page <= page_last ? 3'd0 : page + 3'd1;
                        end else begin
                            col <= col + 7'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    spi_byte_sender #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_sender (
        .clk        (clk),
        .nrst       (nrst),
        .tx_vld     (tx_vld),
        .tx_rdy     (tx_rdy),
        .tx_byte    (tx_byte),
        .tx_dc      (tx_dc),
        .tx_done    (tx_done),
        .tx_timeout (tx_timeout),
        .spi_wr_cmd (bus.spi_wr_cmd),
        .recv_dc    (bus.recv_dc),
        .mosi_data  (bus.mosi_data),
        .spi_busy   (bus.spi_busy)
    );

endmodule

// File: tb/tb_oled_refresh_sequencer.sv
// Bench for oled_refresh_sequencer: spi_master and frame-buffer models plus a byte scoreboard.
// Expected byte streams are queued when a start is issued; the monitor pops on every wr rise.
module tb_oled_refresh_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst;
    logic start;
    logic refresh_en;
    logic busy;
    logic init_done;
    logic frame_done;
    logic err;
    logic oled_rst_n;

    oled_refresh_sequencer_if bus ();

    oled_refresh_sequencer #(
        .RST_LOW_CYCLES  (4),
        .RST_WAIT_CYCLES (6),
        .ACK_TIMEOUT     (10),
        .PAGES           (8),
        .COLS            (128)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .refresh_en (refresh_en),
        .busy       (busy),
        .init_done  (init_done),
        .frame_done (frame_done),
        .err        (err),
        .oled_rst_n (oled_rst_n),
        .bus        (bus)
    );

    logic [7:0] init_tab [25] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
        8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
        8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

    int n_checks = 0;
    int n_err    = 0;
    int n_bytes  = 0;
    int n_fd     = 0;
    int n_rst_low = 0;
    logic [8:0] exp_q [$];
    logic [8:0] exp_b;

    // spi_master / frame-buffer model state
    logic       tied0    = 1'b0;
    int         busy_len = 16;
    logic       wr_q;
    logic       arm;
    int         bcnt;
    logic       cap_vld;
    logic [8:0] cap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_init();
        for (int i = 0; i < 25; i++) exp_q.push_back({1'b0, init_tab[i]});
    endtask

    task automatic push_frame();
        logic [9:0] a;
        for (int p = 0; p < 8; p++) begin
            exp_q.push_back({1'b0, 8'hB0 + 8'(p)});
            exp_q.push_back(9'h000);
            exp_q.push_back(9'h010);
            for (int c = 0; c < 128; c++) begin
                a = 10'(p * 128 + c);
                exp_q.push_back({1'b1, a[7:0]});
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},       32'(busy),           32'd0);
        chk({tag, "_init_done"},  32'(init_done),      32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done),     32'd0);
        chk({tag, "_err"},        32'(err),            32'd0);
        chk({tag, "_oled_rst_n"}, 32'(oled_rst_n),     32'd1);
        chk({tag, "_fb_rd"},      32'(bus.fb_rd),      32'd0);
        chk({tag, "_fb_addr"},    32'(bus.fb_addr),    32'd0);
        chk({tag, "_wr"},         32'(bus.spi_wr_cmd), 32'd0);
        chk({tag, "_dc"},         32'(bus.recv_dc),    32'd0);
        chk({tag, "_mosi"},       32'(bus.mosi_data),  32'd0);
    endtask

    // spi_master goes busy 2 cycles after the wr rise and holds for busy_len cycles.
    always @(posedge clk) begin
        if (!nrst) begin
            wr_q         <= 1'b0;
            arm          <= 1'b0;
            bcnt         <= 0;
            cap_vld      <= 1'b0;
            cap          <= 9'h000;
            bus.spi_busy <= 1'b0;
            bus.fb_data  <= 8'h00;
        end else begin
            wr_q    <= bus.spi_wr_cmd;
            cap_vld <= 1'b0;
            if (tied0) begin
                bus.spi_busy <= 1'b0;
                arm          <= 1'b0;
            end else if (arm) begin
                arm          <= 1'b0;
                bus.spi_busy <= 1'b1;
                bcnt         <= busy_len - 1;
            end else if (bus.spi_busy) begin
                if (bcnt == 0) bus.spi_busy <= 1'b0;
                else           bcnt <= bcnt - 1;
            end
            if (bus.spi_wr_cmd && !wr_q) begin
                cap_vld <= 1'b1;
                cap     <= {bus.recv_dc, bus.mosi_data};
                if (!tied0) arm <= 1'b1;
            end
            if (bus.fb_rd) bus.fb_data <= bus.fb_addr[7:0];
        end
    end

    always @(negedge clk) begin
        if (frame_done)  n_fd++;
        if (!oled_rst_n) n_rst_low++;
        if (cap_vld) begin
            n_bytes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL byte_extra: got %0h with nothing expected", cap);
            end else begin
                exp_b = exp_q.pop_front();
                chk("byte", 32'(cap), 32'(exp_b));
            end
        end
    end

    initial begin
        int lo;
        int n;
        int hi;
        int base;
        nrst       = 1'b0;
        start      = 1'b0;
        refresh_en = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Power-up: reset pulse, init table, one frame; a start during INIT must be ignored.
        push_init();
        push_frame();
        pulse_start();
        lo = 0;
        while (!oled_rst_n && lo < 100) begin lo++; @(negedge clk); end
        chk("rst_low_cycles", 32'(lo), 32'd4);
        n = 0;
        while (!bus.spi_wr_cmd && n < 100) begin n++; @(negedge clk); end
        chk("release_to_wr", 32'(n), 32'd6);
        for (int i = 0; i < 1000 && n_bytes < 10; i++) @(negedge clk);
        chk("wait_10_bytes", 32'(n_bytes >= 10), 32'd1);
        pulse_start();
        for (int i = 0; i < 2000 && !init_done; i++) @(negedge clk);
        chk("init_done", 32'(init_done), 32'd1);
        chk("init_bytes", 32'(n_bytes), 32'd25);
        for (int i = 0; i < 30000 && busy; i++) @(negedge clk);
        chk("frame1_idle", 32'(busy), 32'd0);
        chk("frame1_fd", 32'(n_fd), 32'd1);
        chk("frame1_bytes", 32'(n_bytes), 32'd1073);
        chk("frame1_q", 32'(exp_q.size()), 32'd0);

        // Continuous refresh, dropped during page 3 of the second frame.
        busy_len   = 3;
        n_fd       = 0;
        n_rst_low  = 0;
        base       = n_bytes;
        push_frame();
        push_frame();
        refresh_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 30000 && !(n_fd == 1 && bus.fb_addr[9:7] == 3'd3); i++) @(negedge clk);
        chk("wait_f2_page3", 32'(n_fd == 1 && bus.fb_addr[9:7] == 3'd3), 32'd1);
        refresh_en = 1'b0;
        for (int i = 0; i < 30000 && busy; i++) @(negedge clk);
        chk("refresh_idle", 32'(busy), 32'd0);
        chk("refresh_fd", 32'(n_fd), 32'd2);
        chk("refresh_no_rst", 32'(n_rst_low), 32'd0);
        chk("refresh_bytes", 32'(n_bytes - base), 32'd2096);
        chk("refresh_q", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of page 2, column 50.
        push_frame();
        pulse_start();
        for (int i = 0; i < 20000 && !(bus.fb_rd && bus.fb_addr == 10'd306); i++) @(negedge clk);
        chk("wait_p2c50", 32'(bus.fb_rd && bus.fb_addr == 10'd306), 32'd1);
        repeat (3) @(negedge clk);
        #1 nrst = 1'b0;
        #1 chk_reset_outputs("arst");
        exp_q.delete();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        n_fd = 0;
        push_init();
        push_frame();
        pulse_start();
        lo = 0;
        while (!oled_rst_n && lo < 100) begin lo++; @(negedge clk); end
        chk("rerun_rst_low", 32'(lo), 32'd4);
        for (int i = 0; i < 20000 && busy; i++) @(negedge clk);
        chk("rerun_idle", 32'(busy), 32'd0);
        chk("rerun_init_done", 32'(init_done), 32'd1);
        chk("rerun_fd", 32'(n_fd), 32'd1);
        chk("rerun_q", 32'(exp_q.size()), 32'd0);

        // spi_master never acknowledges: timeout, sticky err, retry on a new start.
        tied0 = 1'b1;
        exp_q.push_back(9'h0B0);
        pulse_start();
        for (int i = 0; i < 50 && !bus.spi_wr_cmd; i++) @(negedge clk);
        chk("wait_wr", 32'(bus.spi_wr_cmd), 32'd1);
        hi = 0;
        while (bus.spi_wr_cmd && hi < 100) begin hi++; @(negedge clk); end
        chk("wr_high_cycles", 32'(hi), 32'd10);
        chk("to_err", 32'(err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_init_done", 32'(init_done), 32'd1);
        exp_q.push_back(9'h0B0);
        pulse_start();
        chk("retry_busy", 32'(busy), 32'd1);
        chk("retry_err", 32'(err), 32'd1);
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        chk("retry_idle", 32'(busy), 32'd0);
        chk("retry_err_end", 32'(err), 32'd1);
        chk("retry_q", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
